bus_reader_arb: RTL and testbench

Read-side counterpart of the shared-bus register loader. Four 16-bit register sources (a, b, c, d) each request to place their word on one shared output bus. A round-robin arbiter grants one source at a time, captures its word into an output holding register, and acknowledges the source. The word is then presented to a downstream consumer with a valid/ready handshake.

---
 rtl/bus_reader_arb.sv | 103 ++++++++++
 tb/tb_bus_reader_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bus_reader_arb.sv
// Round-robin read arbiter: captures one of four source words into a registered
// output and presents it downstream with a valid/ready handshake.
module bus_reader_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             c_req,
  input  logic             d_req,
  input  logic             out_ready,
  output logic             a_ack,
  output logic             b_ack,
  output logic             c_ack,
  output logic             d_ack,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic [1:0]       src_id,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [3:0]       req_vec;
  logic [3:0]       ack_vec;
  logic             found;
  logic [1:0]       sel;
  logic [WIDTH-1:0] sel_word;

  assign req_vec = {d_req, c_req, b_req, a_req};
  assign {d_ack, c_ack, b_ack, a_ack} = ack_vec;

  // NOTE: every combinational output gets a default before the loop/case so no latch is inferred.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    sel   = ptr;
    idx   = ptr;
    // Scan from the farthest offset down so the requester closest to ptr wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req_vec[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_word = a;
    case (sel)
      2'd0:    sel_word = a;
      2'd1:    sel_word = b;
      2'd2:    sel_word = c;
      default: sel_word = d;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      ack_vec    <= 4'b0000;
      data       <= '0;
      data_valid <= 1'b0;
      src_id     <= 2'd0;
      busy       <= 1'b0;
    end else begin
      ack_vec <= 4'b0000;
      case (state)
        IDLE: begin
          if (found) begin
            data         <= sel_word;
            src_id       <= sel;
            data_valid   <= 1'b1;
            busy         <= 1'b1;
            ack_vec[sel] <= 1'b1;
            ptr          <= sel + 2'd1;
            state        <= HOLD;
          end
        end
        default: begin
          // Capture and transfer never share an edge, so IDLE always lasts a cycle.
          if (out_ready) begin
            data_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reader_arb.sv
// Directed testbench for bus_reader_arb: reset, single read, backpressure,
// round-robin order, pointer wrap and reset during HOLD.
module tb_bus_reader_arb;

  logic        clk;
  logic        reset;
  logic [15:0] a, b, c, d;
  logic        a_req, b_req, c_req, d_req;
  logic        out_ready;
  logic        a_ack, b_ack, c_ack, d_ack;
  logic [15:0] data;
  logic        data_valid;
  logic [1:0]  src_id;
  logic        busy;

  int n_checks;
  int n_fail;

  bus_reader_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .a_req      (a_req),
    .b_req      (b_req),
    .c_req      (c_req),
    .d_req      (d_req),
    .out_ready  (out_ready),
    .a_ack      (a_ack),
    .b_ack      (b_ack),
    .c_ack      (c_ack),
    .d_ack      (d_ack),
    .data       (data),
    .data_valid (data_valid),
    .src_id     (src_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] acks();
    return {d_ack, c_ack, b_ack, a_ack};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},  32'(data),       32'h0);
    check({tag, "_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_src"},   32'(src_id),     32'h0);
    check({tag, "_acks"},  32'(acks()),     32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
  endtask

  logic [15:0] words [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    a = 16'h0; b = 16'h0; c = 16'h0; d = 16'h0;
    a_req = 1'b0; b_req = 1'b0; c_req = 1'b0; d_req = 1'b0;
    out_ready = 1'b0;
    #3;
    check_reset_state("por");
    step();
    step();
    reset = 1'b1;

    // Single read from B with the consumer ready.
    b = 16'h1234; b_req = 1'b1; out_ready = 1'b1;
    step();
    check("rd_ack",   32'(acks()),     32'b0010);
    check("rd_data",  32'(data),       32'h1234);
    check("rd_src",   32'(src_id),     32'd1);
    check("rd_valid", 32'(data_valid), 32'd1);
    check("rd_busy",  32'(busy),       32'd1);
    b_req = 1'b0;
    step();
    check("rd_ack_off", 32'(acks()),     32'b0000);
    check("rd_xfer",    32'(data_valid), 32'd0);
    check("rd_idle",    32'(busy),       32'd0);
    check("rd_keep",    32'(data),       32'h1234);

    // Backpressure on C; source word changes after the ack.
    out_ready = 1'b0; c = 16'hBEEF; c_req = 1'b1;
    step();
    check("bp_ack",  32'(acks()), 32'b0100);
    check("bp_data", 32'(data),   32'hBEEF);
    check("bp_src",  32'(src_id), 32'd2);
    c_req = 1'b0; c = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_data",  32'(data),       32'hBEEF);
      check("bp_hold_valid", 32'(data_valid), 32'd1);
      check("bp_hold_ack",   32'(acks()),     32'b0000);
    end
    out_ready = 1'b1;
    step();
    check("bp_xfer", 32'(data_valid), 32'd0);

    // ptr is now 3: D wins; reset lands while D's word is held.
    out_ready = 1'b0; d = 16'hD00D; d_req = 1'b1;
    step();
    check("rs_ack", 32'(acks()), 32'b1000);
    check("rs_src", 32'(src_id), 32'd3);
    d_req = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    step();
    reset = 1'b1;
    step();
    check("rs_idle", 32'(data_valid), 32'd0);

    // Round-robin: all four request together from ptr=0.
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC; words[3] = 16'hDDDD;
    a = words[0]; b = words[1]; c = words[2]; d = words[3];
    a_req = 1'b1; b_req = 1'b1; c_req = 1'b1; d_req = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_ack",  32'(acks()), 32'(4'b0001 << k));
      check("rr_src",  32'(src_id), 32'(k));
      check("rr_data", 32'(data),   32'(words[k]));
      case (k)
        0: a_req = 1'b0;
        1: b_req = 1'b0;
        2: c_req = 1'b0;
        default: d_req = 1'b0;
      endcase
      step();
      check("rr_gap_ack",   32'(acks()),     32'b0000);
      check("rr_gap_valid", 32'(data_valid), 32'd0);
    end

    // Wrap: after D, A beats C.
    a_req = 1'b1; c_req = 1'b1;
    step();
    check("wrap_a_ack", 32'(acks()), 32'b0001);
    check("wrap_a_src", 32'(src_id), 32'd0);
    a_req = 1'b0;
    step();
    step();
    check("wrap_c_ack", 32'(acks()), 32'b0100);
    check("wrap_c_src", 32'(src_id), 32'd2);
    c_req = 1'b0;
    step();

    // Reset during HOLD with a_req held: fresh grant after release.
    a = 16'h5A5A; a_req = 1'b1; out_ready = 1'b0;
    step();
    check("rh_ack",   32'(acks()), 32'b0001);
    check("rh_data",  32'(data),   32'h5A5A);
    reset = 1'b0;
    #1;
    check("rh_valid_drop", 32'(data_valid), 32'd0);
    check("rh_ack_drop",   32'(acks()),     32'b0000);
    step();
    check("rh_in_reset", 32'(data_valid), 32'd0);
    reset = 1'b1;
    #3;
    check("rh_no_stale", 32'(data_valid), 32'd0);
    step();
    check("rh_regrant_ack",   32'(acks()),     32'b0001);
    check("rh_regrant_valid", 32'(data_valid), 32'd1);
    check("rh_regrant_data",  32'(data),       32'h5A5A);
    a_req = 1'b0; out_ready = 1'b1;
    step();
    check("rh_xfer", 32'(data_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
